// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared encodings for the SRAM port arbiter.
//   state_t : arbiter FSM states (idle, granted to port 0, granted to port 1)
//   op_t    : latched command type (read / write)
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_GNT0 = 2'b01,
    S_GNT1 = 2'b10
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational winner select between two requesters.
//   req0, req1 : per-port request (read_en | write_en)
//   last_grant : index of the port granted most recently (0 or 1)
//   gnt        : one-hot winner, 2'b00 when nobody requests
// Build option SRAM_ARB_ROUND_ROBIN_EN: when defined, ties alternate away
// from last_grant; otherwise port 1 (data side) always wins ties.
module sram_arb_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic [1:0] gnt
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end else if (req1) begin
      gnt = 2'b10;
    end else if (req0) begin
      gnt = 2'b01;
    end
  end
`else
  // Fixed priority: history is tracked by the caller but not consulted here.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    gnt = 2'b00;
    if (req1) begin
      gnt = 2'b10;
    end else if (req0) begin
      gnt = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller port between the instruction-fetch
// side (port 0) and the data-side cache controller (port 1).
//   clk, rst                 : clock, asynchronous active-low reset
//   reqN_addr/_write_data    : requester command
//   reqN_read_en/_write_en   : level requests, held until reqN_ready
//   reqN_read_data/_ready    : line and single-cycle completion, owner only
//   sram_addr/_write_data    : latched command, stable while granted
//   sram_read_en/_write_en   : SRAM strobes (level) for the latched op
//   sram_read_data/_ready    : SRAM line and single-cycle completion
//   grant, busy              : one-hot owner, transaction in flight
// Build option SRAM_ARB_ROUND_ROBIN_EN selects the tie policy (see sram_arb_pick).
module sram_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned WDATA_W = 32,
  parameter int unsigned RDATA_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [WDATA_W-1:0] req0_write_data,
  input  logic               req0_read_en,
  input  logic               req0_write_en,
  output logic [RDATA_W-1:0] req0_read_data,
  output logic               req0_ready,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [WDATA_W-1:0] req1_write_data,
  input  logic               req1_read_en,
  input  logic               req1_write_en,
  output logic [RDATA_W-1:0] req1_read_data,
  output logic               req1_ready,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [WDATA_W-1:0] sram_write_data,
  output logic               sram_read_en,
  output logic               sram_write_en,
  input  logic [RDATA_W-1:0] sram_read_data,
  input  logic               sram_ready,
  output logic [1:0]         grant,
  output logic               busy
);
  import sram_arbiter_pkg::*;

  state_t             state, state_nxt;
  logic               last_grant;
  logic [ADDR_W-1:0]  lat_addr;
  logic [WDATA_W-1:0] lat_wdata;
  op_t                lat_op;

  logic       req0, req1;
  logic [1:0] pick;

  assign req0 = req0_read_en | req0_write_en;
  assign req1 = req1_read_en | req1_write_en;

  sram_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .gnt        (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_op     <= OP_RD;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && pick != 2'b00) begin
        last_grant <= pick[1];
        if (pick[1]) begin
          lat_addr  <= req1_addr;
          lat_wdata <= req1_write_data;
          // write wins when both enables are high
          lat_op    <= req1_write_en ? OP_WR : OP_RD;
        end else begin
          lat_addr  <= req0_addr;
          lat_wdata <= req0_write_data;
          lat_op    <= req0_write_en ? OP_WR : OP_RD;
        end
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    grant           = 2'b00;
    busy            = 1'b0;
    sram_addr       = '0;
    sram_write_data = '0;
    sram_read_en    = 1'b0;
    sram_write_en   = 1'b0;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    req0_read_data  = '0;
    req1_read_data  = '0;

    case (state)
      S_IDLE: begin
        // sram_ready is ignored here; only a fresh grant leaves idle
        if (pick[1]) begin
          state_nxt = S_GNT1;
        end else if (pick[0]) begin
          state_nxt = S_GNT0;
        end
      end
      S_GNT0, S_GNT1: begin
        grant           = (state == S_GNT0) ? 2'b01 : 2'b10;
        busy            = 1'b1;
        sram_addr       = lat_addr;
        sram_write_data = lat_wdata;
        sram_read_en    = (lat_op == OP_RD);
        sram_write_en   = (lat_op == OP_WR);
        if (sram_ready) begin
          state_nxt = S_IDLE;
          if (state == S_GNT0) begin
            req0_ready = 1'b1;
            if (lat_op == OP_RD) req0_read_data = sram_read_data;
          end else begin
            req1_ready = 1'b1;
            if (lat_op == OP_RD) req1_read_data = sram_read_data;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed, table-driven bench for sram_arbiter.
// Inputs are applied just after the falling edge; outputs are compared 1 ns later.
module tb_sram_arbiter;

  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [63:0] Z64 = 64'h0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] req0_addr, req0_write_data, req1_addr, req1_write_data;
  logic        req0_read_en, req0_write_en, req1_read_en, req1_write_en;
  logic [63:0] req0_read_data, req1_read_data, sram_read_data;
  logic        req0_ready, req1_ready, sram_ready;
  logic [31:0] sram_addr, sram_write_data;
  logic        sram_read_en, sram_write_en, busy;
  logic [1:0]  grant;

  sram_arbiter #(.ADDR_W(32), .WDATA_W(32), .RDATA_W(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .req0_addr       (req0_addr),
    .req0_write_data (req0_write_data),
    .req0_read_en    (req0_read_en),
    .req0_write_en   (req0_write_en),
    .req0_read_data  (req0_read_data),
    .req0_ready      (req0_ready),
    .req1_addr       (req1_addr),
    .req1_write_data (req1_write_data),
    .req1_read_en    (req1_read_en),
    .req1_write_en   (req1_write_en),
    .req1_read_data  (req1_read_data),
    .req1_ready      (req1_ready),
    .sram_addr       (sram_addr),
    .sram_write_data (sram_write_data),
    .sram_read_en    (sram_read_en),
    .sram_write_en   (sram_write_en),
    .sram_read_data  (sram_read_data),
    .sram_ready      (sram_ready),
    .grant           (grant),
    .busy            (busy)
  );

  typedef struct {
    logic        r0rd, r0wr, r1rd, r1wr;
    logic [31:0] a0, a1, w0, w1;
    logic        srdy;
    logic [63:0] srd;
    logic [1:0]  g;
    logic        busy, erd, ewr;
    logic [31:0] ea, ew;
    logic        rdy0, rdy1;
    logic [63:0] d0, d1;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t zv();
    vec_t v;
    v = '{r0rd: L, r0wr: L, r1rd: L, r1wr: L, a0: Z32, a1: Z32, w0: Z32, w1: Z32,
          srdy: L, srd: Z64, g: 2'b00, busy: L, erd: L, ewr: L, ea: Z32, ew: Z32,
          rdy0: L, rdy1: L, d0: Z64, d1: Z64};
    return v;
  endfunction

  // Expected outputs while port `port` owns the SRAM with the given latched command.
  function automatic vec_t gexp(input vec_t vi, input bit port, input logic wr,
                                input logic [31:0] a, input logic [31:0] w);
    vec_t v;
    v      = vi;
    v.g    = port ? 2'b10 : 2'b01;
    v.busy = H;
    v.erd  = ~wr;
    v.ewr  = wr;
    v.ea   = a;
    v.ew   = w;
    if (v.srdy) begin
      if (port) begin
        v.rdy1 = H;
        v.d1   = wr ? Z64 : v.srd;
      end else begin
        v.rdy0 = H;
        v.d0   = wr ? Z64 : v.srd;
      end
    end
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req0_read_en    = v.r0rd;
    req0_write_en   = v.r0wr;
    req1_read_en    = v.r1rd;
    req1_write_en   = v.r1wr;
    req0_addr       = v.a0;
    req1_addr       = v.a1;
    req0_write_data = v.w0;
    req1_write_data = v.w1;
    sram_ready      = v.srdy;
    sram_read_data  = v.srd;
  endtask

  task automatic check_out(input vec_t v, input string tag);
    chk({tag, ".grant"},      64'(grant),           64'(v.g));
    chk({tag, ".busy"},       64'(busy),            64'(v.busy));
    chk({tag, ".sram_rd"},    64'(sram_read_en),    64'(v.erd));
    chk({tag, ".sram_wr"},    64'(sram_write_en),   64'(v.ewr));
    chk({tag, ".sram_addr"},  64'(sram_addr),       64'(v.ea));
    chk({tag, ".sram_wdata"}, 64'(sram_write_data), 64'(v.ew));
    chk({tag, ".ready0"},     64'(req0_ready),      64'(v.rdy0));
    chk({tag, ".ready1"},     64'(req1_ready),      64'(v.rdy1));
    chk({tag, ".rdata0"},     req0_read_data,       v.d0);
    chk({tag, ".rdata1"},     req1_read_data,       v.d1);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    check_out(v, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(zv());
    rst = L;
    @(negedge clk);
    rst = H;
  endtask

  initial begin
    vec_t v;
    bit   first;

    // single read on port 0, SRAM answers 3 cycles after the strobe
    tbl[0]  = '{H,L,L,L, 32'h10,Z32,Z32,Z32, L,Z64, 2'b00,L,L,L, Z32,Z32, L,L, Z64,Z64};
    tbl[1]  = '{H,L,L,L, 32'h10,Z32,Z32,Z32, L,Z64, 2'b01,H,H,L, 32'h10,Z32, L,L, Z64,Z64};
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = '{H,L,L,L, 32'h10,Z32,Z32,Z32, H,64'h0000_0002_0000_0001, 2'b01,H,H,L, 32'h10,Z32, H,L, 64'h0000_0002_0000_0001,Z64};
    // sram_ready while idle is ignored
    tbl[5]  = '{L,L,L,L, Z32,Z32,Z32,Z32, H,64'hDEAD, 2'b00,L,L,L, Z32,Z32, L,L, Z64,Z64};
    // withdrawal: request dropped and address changed after grant
    tbl[6]  = '{H,L,L,L, 32'h40,Z32,Z32,Z32, L,Z64, 2'b00,L,L,L, Z32,Z32, L,L, Z64,Z64};
    tbl[7]  = '{L,L,L,L, 32'hFF,Z32,Z32,Z32, L,Z64, 2'b01,H,H,L, 32'h40,Z32, L,L, Z64,Z64};
    tbl[8]  = '{L,L,L,L, 32'hFF,Z32,Z32,Z32, H,64'h11, 2'b01,H,H,L, 32'h40,Z32, H,L, 64'h11,Z64};
    tbl[9]  = zv();
    // both enables on port 1: write is taken, no read data returned
    tbl[10] = '{L,L,H,H, Z32,32'h80,Z32,32'hCAFE_F00D, L,Z64, 2'b00,L,L,L, Z32,Z32, L,L, Z64,Z64};
    tbl[11] = '{L,L,H,H, Z32,32'h80,Z32,32'hCAFE_F00D, H,64'hFFFF_FFFF_FFFF_FFFF, 2'b10,H,L,H, 32'h80,32'hCAFE_F00D, L,H, Z64,Z64};
    tbl[12] = zv();

    // reset state: requests and sram_ready present but ignored
    rst = L;
    v = zv();
    v.r1wr = H; v.a1 = 32'h1234; v.w1 = 32'h5678; v.srdy = H; v.srd = 64'h5;
    apply(v, "reset");
    @(negedge clk);
    drive(zv());
    rst = H;

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // simultaneous port 0 read and port 1 write, right after reset (last_grant=1)
    do_reset();
    v = zv();
    v.r0rd = H; v.a0 = 32'h30; v.w0 = 32'h55;
    v.r1wr = H; v.a1 = 32'h20; v.w1 = 32'hDEAD_BEEF;
    apply(v, "tie_idle");
    first = RR ? 1'b0 : 1'b1;
    v.srdy = H; v.srd = 64'h1234;
    apply(first ? gexp(v, 1'b1, H, 32'h20, 32'hDEAD_BEEF)
                : gexp(v, 1'b0, L, 32'h30, 32'h55), "tie_first");
    v.srdy = L; v.srd = Z64;
    if (first) v.r1wr = L;
    else       v.r0rd = L;
    apply(v, "tie_gap");
    v.srdy = H; v.srd = 64'hABCD;
    apply(first ? gexp(v, 1'b0, L, 32'h30, 32'h55)
                : gexp(v, 1'b1, H, 32'h20, 32'hDEAD_BEEF), "tie_second");

    // both ports requesting continuously for four transactions
    do_reset();
    v = zv();
    v.r0rd = H; v.a0 = 32'h100;
    v.r1rd = H; v.a1 = 32'h200;
    for (int i = 0; i < 4; i++) begin
      vec_t g;
      bit   p;
      apply(v, $sformatf("cont%0d_idle", i));
      p = RR ? bit'(i % 2) : 1'b1;
      g = v;
      g.srdy = H;
      g.srd  = 64'(i + 1);
      apply(gexp(g, p, L, p ? 32'h200 : 32'h100, Z32), $sformatf("cont%0d_gnt", i));
    end

    // reset while port 1 owns the SRAM, before sram_ready
    v = zv();
    v.r1rd = H; v.a1 = 32'h90;
    apply(v, "mid_idle");
    apply(gexp(v, 1'b1, L, 32'h90, Z32), "mid_gnt");
    #2;
    rst = L;
    v.srdy = H; v.srd = 64'h77;
    drive(v);
    #1;
    check_out(v, "mid_rst");
    apply(v, "mid_hold");
    @(negedge clk);
    drive(zv());
    rst = H;
    v = zv();
    v.r0rd = H; v.a0 = 32'h44;
    apply(v, "post_idle");
    v.srdy = H; v.srd = 64'h99;
    apply(gexp(v, 1'b0, L, 32'h44, Z32), "post_gnt");

    @(negedge clk);
    drive(zv());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM controller port between two requesters.
  - Port 0: the instruction-fetch side.
  - Port 1: the data-side cache controller.
- Arbitrates between requests, latches the winner's command, and holds it stable on the SRAM interface until sram_ready.
- Returns read data and a one-cycle ready pulse to the winner only.
- Sits between the pipeline-side memory clients and the SRAM controller.

Parameters:
- ADDR_W, 32, address width of requesters and SRAM port.
- WDATA_W, 32, write data width.
- RDATA_W, 64, SRAM read line width (two words).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req0_addr  in  ADDR_W  port 0 address.
- req0_write_data  in  WDATA_W  port 0 write data.
- req0_read_en  in  1  port 0 read request (level, held until req0_ready).
- req0_write_en  in  1  port 0 write request (level, held until req0_ready).
- req0_read_data  out  RDATA_W  line returned to port 0.
- req0_ready  out  1  port 0 completion pulse.
- req1_addr, req1_write_data, req1_read_en, req1_write_en, req1_read_data, req1_ready: same as port 0, for port 1.
- sram_addr  out  ADDR_W  latched address.
- sram_write_data  out  WDATA_W  latched write data.
- sram_read_en  out  1  SRAM read strobe (level).
- sram_write_en  out  1  SRAM write strobe (level).
- sram_read_data  in  RDATA_W  SRAM line.
- sram_ready  in  1  SRAM completion, single cycle.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  transaction in flight.

Behaviour:
- Reset (rst=0, async):
  - State S_IDLE, last_grant=1.
  - Latched command registers = 0.
  - All outputs 0.
- Request per port: req = read_en | write_en. If both enables are high on one port, the write is taken; the read is ignored.
- States: S_IDLE, S_GNT0, S_GNT1.
- S_IDLE:
  - Evaluate requests each cycle.
  - One requester: grant it.
  - Both requesters: policy per Optional Feature.
  - On grant, latch addr, write_data and op (rd/wr) from the winner; move to S_GNTx on the next edge; update last_grant.
  - No request: stay in S_IDLE.
- S_GNTx:
  - grant[x]=1, busy=1.
  - sram_addr/sram_write_data driven from latches.
  - sram_read_en or sram_write_en = latched op.
  - Wait for sram_ready.
- Completion, in the cycle sram_ready=1 while in S_GNTx:
  - reqx_ready=1, combinational.
  - For reads, reqx_read_data = sram_read_data; for writes it is 0.
  - Next state S_IDLE.
- Non-owner: ready=0 and read_data=0 at all times.
- Latency:
  - Grant is 1 cycle after request.
  - Total = 1 + SRAM latency.
  - Always one S_IDLE cycle between back-to-back transactions; the SRAM enables drop for that cycle.
- Request withdrawn mid-transaction: tolerated. The latched command completes and the ready pulse is still issued. A requester must not re-raise the request in the ready cycle expecting a new transaction; the next sample happens in S_IDLE.
- sram_ready asserted in S_IDLE is ignored.
- Unused sram_* outputs are 0 when not in S_GNTx.
- Reset mid-transaction: abort immediately to reset values; no ready pulse is issued.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in S_IDLE, grant the port ≠ last_grant (alternating).
- Undefined: fixed priority; port 1 (data side) always wins ties. last_grant is still maintained but unused in the decision.

Decomposition:
- Shared package/defines: state encodings S_IDLE=2'b00, S_GNT0=2'b01, S_GNT1=2'b10; op encoding OP_RD=1'b0, OP_WR=1'b1.
- One natural sub-module: sram_arb_pick, a combinational winner select from (req0, req1, last_grant) → one-hot grant. Policy is selected inside it via the macro.

Test Plan:
- Single read, port 0:
  - Stimulus: req0_read_en=1, addr=0x0000_0010; SRAM answers 3 cycles after strobe with line 0x0000_0002_0000_0001.
  - Required: sram_read_en high from cycle 1; req0_ready pulses once with read_data=0x0000_0002_0000_0001; req1_ready stays 0.
- Simultaneous port 0 read and port 1 write (addr 0x20, data 0xDEADBEEF):
  - Macro off: port 1 is granted first (sram_write_en, data 0xDEADBEEF), then port 0.
  - Macro on with last_grant=1: port 0 is granted first.
- Round robin, macro on:
  - Stimulus: both ports hold requests continuously for 4 transactions.
  - Required: grant sequence alternates 01,10,01,10, with one idle cycle between each.
- Withdrawal:
  - Stimulus: port 0 drops read_en and changes addr to 0xFF one cycle after grant.
  - Required: sram_addr stays at the latched value; req0_ready still pulses.
- Reset mid-op:
  - Stimulus: assert rst=0 while in S_GNT1 before sram_ready.
  - Required: all outputs go to 0 immediately; no ready pulse; after release, a new request is granted normally.
- Both enables on one port:
  - Stimulus: req1_read_en=req1_write_en=1.
  - Required: only sram_write_en asserts; req1_read_data=0 on ready.
